mul_sequencer: RTL

Multi-cycle multiply controller for the EX stage of the 5-stage RV64 pipeline. It accepts an M-extension multiply from EX, latches the operands, and iterates a DATA_W×BITS_PER_CYCLE partial-product datapath over DATA_W/BITS_PER_CYCLE cycles. It holds a stall that freezes PC, IF/ID, ID/EX and EX/MEM until the result is valid. The result is then presented for one cycle, so EX/MEM captures it in place of the ALU output.

---
 rtl/mul_sequencer.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mul_sequencer.sv
// ---------------------------------------------------------------------------
// MulSequencer : multi-cycle multiply controller for the EX stage.
//
// Accepts an M-extension multiply from EX, latches the operands and walks a
// DATA_W x BITS_PER_CYCLE partial-product datapath over STEPS cycles
// (STEPS = DATA_W / BITS_PER_CYCLE). While the multiply is in flight the
// pipeline is frozen through 'stall'. The finished product is shown for a
// single DONE cycle so that EX/MEM can capture it in place of the ALU output.
//
// Ports
//   clk        in   1       single clock, rising edge
//   arst_n     in   1       synchronous active-low reset
//   start      in   1       EX holds a valid multiply
//   func3      in   3       000 MUL, 001 MULH, 010 MULHSU, 011 MULHU (bit 2 ignored)
//   operand_a  in   DATA_W  rs1 value
//   operand_b  in   DATA_W  rs2 value
//   stall      out  1       freeze request for PC and pipeline registers
//   busy       out  1       sequencer is not idle
//   done       out  1       one-cycle pulse, result valid
//   result     out  DATA_W  selected product half, zero when done is low
//
// Build option
//   MUL_HIGH_EN : when defined, MULH/MULHSU/MULHU are supported with a full
//                 2*DATA_W accumulator. When undefined, every request behaves
//                 as MUL, the sign logic is absent and the accumulator is
//                 DATA_W bits wide. Latency is identical in both builds.
// ---------------------------------------------------------------------------
module mul_sequencer #(
    parameter int DATA_W         = 64,
    parameter int BITS_PER_CYCLE = 16
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic [2:0]        func3,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    output logic              stall,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam int STEPS = DATA_W / BITS_PER_CYCLE;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
`ifdef MUL_HIGH_EN
    localparam int ACC_W = 2 * DATA_W;
`else
    localparam int ACC_W = DATA_W;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [ACC_W-1:0]          acc_q, acc_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic [DATA_W-1:0]         magA_q, magA_d;
    logic [DATA_W-1:0]         magB_q, magB_d;
`ifdef MUL_HIGH_EN
    logic [1:0]                func_q, func_d;
    logic                      neg_q, neg_d;
`endif

    logic [BITS_PER_CYCLE-1:0] chunk;
    logic [ACC_W-1:0]          partial;
    logic [ACC_W-1:0]          shifted;
    logic                      lastStep;

`ifdef MUL_HIGH_EN
    logic                      aIsSigned;
    logic                      bIsSigned;
    logic                      aNegative;
    logic                      bNegative;
    logic [DATA_W-1:0]         absA;
    logic [DATA_W-1:0]         absB;
    logic [ACC_W-1:0]          accSigned;

    // Operand magnitudes and product sign at issue time. The most-negative
    // value negates onto itself, which read as unsigned is exactly
    // 2^(DATA_W-1), so the magnitude path never overflows.
    always_comb begin
        aIsSigned = (func3[1:0] == 2'b01) || (func3[1:0] == 2'b10);
        bIsSigned = (func3[1:0] == 2'b01);
        aNegative = aIsSigned && operand_a[DATA_W-1];
        bNegative = bIsSigned && operand_b[DATA_W-1];
        absA      = aNegative ? (~operand_a + DATA_W'(1)) : operand_a;
        absB      = bNegative ? (~operand_b + DATA_W'(1)) : operand_b;
    end
`endif

    // One step of the partial-product datapath: the current multiplier chunk
    // times the full multiplicand, shifted into its column. In the low-only
    // build the product is simply truncated to the accumulator width, which
    // is harmless because accumulation is modular anyway.
    always_comb begin
        chunk    = magB_q[int'(count_q) * BITS_PER_CYCLE +: BITS_PER_CYCLE];
        partial  = ACC_W'(magA_q) * ACC_W'(chunk);
        shifted  = partial << (int'(count_q) * BITS_PER_CYCLE);
        lastStep = (count_q == CNT_W'(STEPS - 1));
    end

    // Next-state logic. Inputs are only looked at in IDLE; once a multiply
    // is accepted everything works from the latched copies, so EX may change
    // its operands freely while the pipeline is stalled.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        magA_d  = magA_q;
        magB_d  = magB_q;
`ifdef MUL_HIGH_EN
        func_d  = func_q;
        neg_d   = neg_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_BUSY;
                    acc_d   = '0;
                    count_d = '0;
`ifdef MUL_HIGH_EN
                    func_d  = func3[1:0];
                    magA_d  = absA;
                    magB_d  = absB;
                    neg_d   = aNegative ^ bNegative;
`else
                    magA_d  = operand_a;
                    magB_d  = operand_b;
`endif
                end
            end
            ST_BUSY: begin
                acc_d   = acc_q + shifted;
                count_d = count_q + CNT_W'(1);
                if (lastStep) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // A start seen here belongs to the instruction still sitting
                // in EX; the pipeline only advances at the end of this cycle.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset. A reset while a
    // multiply is in flight simply abandons it.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            magA_q  <= '0;
            magB_q  <= '0;
`ifdef MUL_HIGH_EN
            func_q  <= 2'b00;
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            magA_q  <= magA_d;
            magB_q  <= magB_d;
`ifdef MUL_HIGH_EN
            func_q  <= func_d;
            neg_q   <= neg_d;
`endif
        end
    end

    // Outputs. The sign is applied to the full-width accumulator only in
    // DONE, and result is forced to zero otherwise so nothing stale leaks
    // into EX/MEM.
    always_comb begin
        stall  = ((state_q == ST_IDLE) && start) || (state_q == ST_BUSY);
        busy   = (state_q != ST_IDLE);
        done   = (state_q == ST_DONE);
        result = '0;
`ifdef MUL_HIGH_EN
        accSigned = neg_q ? ('0 - acc_q) : acc_q;
        if (state_q == ST_DONE) begin
            if (func_q == 2'b00) begin
                result = accSigned[DATA_W-1:0];
            end else begin
                result = accSigned[ACC_W-1:DATA_W];
            end
        end
`else
        if (state_q == ST_DONE) begin
            result = acc_q;
        end
`endif
    end

endmodule
